// File: rtl/free_request_arbiter_queue.sv
// Multi-channel free() request arbiter and queue in front of the allocator.
// Each channel can hold one request waiting for an enqueue slot. Channels are
// served round-robin into a circular FIFO, and the FIFO is drained one address
// at a time through an idle handshake with the allocator.
module free_request_arbiter_queue #(
  parameter int NUM_CH = 2,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_CH-1:0]            free_request_i,
  input  logic [NUM_CH*ADDR_W-1:0]     free_addr_i,
  output logic [NUM_CH-1:0]            free_finish_o,
  input  logic                         idle,
  input  logic                         analysis,
  output logic                         free_request_o,
  output logic [ADDR_W-1:0]            free_address_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  output logic                         full_o,
  output logic                         drop_err_o
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    READY     = 2'd0,
    WAIT_BUSY = 2'd1,
    WAIT_IDLE = 2'd2
  } state_e;

  // Channel-side state
  logic [NUM_CH-1:0] pend_q, pend_d;
  logic [ADDR_W-1:0] pend_addr_q [NUM_CH];
  logic [ADDR_W-1:0] pend_addr_d [NUM_CH];
  logic [NUM_CH-1:0] finish_q, finish_d;
  logic [CH_W-1:0]   rr_q, rr_d;
  logic              drop_err_q, drop_err_d;

  // FIFO state
  logic [ADDR_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;

  // Issue FSM state and registered outputs
  state_e            state_q;
  logic              free_request_q;
  logic [ADDR_W-1:0] free_address_q;

  // Decoded request / arbitration signals
  logic [ADDR_W-1:0] req_addr_s  [NUM_CH];
  logic [ADDR_W-1:0] cand_addr_s [NUM_CH];
  logic [NUM_CH-1:0] live_s, null_s, cand_s, won_s;
  logic              win_found_s;
  logic [CH_W-1:0]   win_idx_s;
  logic [ADDR_W-1:0] win_addr_s;
  int                dist_s, best_dist_s;
  logic              push_s, pop_s;

  // Split incoming requests into NULL and real frees; a pending entry takes the
  // place of any live request on its channel as the arbitration candidate.
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      req_addr_s[c]  = free_addr_i[c*ADDR_W +: ADDR_W];
      live_s[c]      = free_request_i[c] && (req_addr_s[c] != '0);
      null_s[c]      = free_request_i[c] && (req_addr_s[c] == '0);
      cand_s[c]      = pend_q[c] || live_s[c];
      cand_addr_s[c] = pend_q[c] ? pend_addr_q[c] : req_addr_s[c];
    end
  end

  // Round-robin pick: the candidate closest (cyclically) to rr_q wins.
  always_comb begin
    win_found_s = 1'b0;
    win_idx_s   = '0;
    win_addr_s  = '0;
    best_dist_s = NUM_CH;
    dist_s      = 0;
    for (int c = 0; c < NUM_CH; c++) begin
      dist_s = (c + NUM_CH - int'(rr_q)) % NUM_CH;
      if (cand_s[c] && (dist_s < best_dist_s)) begin
        best_dist_s = dist_s;
        win_found_s = 1'b1;
        win_idx_s   = CH_W'(c);
        win_addr_s  = cand_addr_s[c];
      end else begin
        best_dist_s = best_dist_s;
      end
    end
  end

  // Push/pop decisions; the full check deliberately ignores a same-cycle pop.
  assign push_s = win_found_s && (count_q != DEPTH_C);
  assign pop_s  = (state_q == READY) && (count_q != '0) && idle && !analysis;

  // Next-state for pending bits, acknowledges, round-robin pointer and drop flag.
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      won_s[c]       = push_s && (win_idx_s == CH_W'(c));
      finish_d[c]    = won_s[c] || null_s[c];
      if (won_s[c]) begin
        pend_d[c]      = 1'b0;
        pend_addr_d[c] = pend_addr_q[c];
      end else if (live_s[c] && !pend_q[c]) begin
        pend_d[c]      = 1'b1;
        pend_addr_d[c] = req_addr_s[c];
      end else begin
        pend_d[c]      = pend_q[c];
        pend_addr_d[c] = pend_addr_q[c];
      end
    end
    drop_err_d = drop_err_q || (|(live_s & pend_q));
    if (push_s) begin
      rr_d = (int'(win_idx_s) == NUM_CH - 1) ? '0 : win_idx_s + CH_W'(1);
    end else begin
      rr_d = rr_q;
    end
  end

  // Next-state for FIFO pointers and occupancy.
  always_comb begin
    wr_ptr_d = push_s ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop_s  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Channel and FIFO control registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pend_q     <= '0;
      finish_q   <= '0;
      rr_q       <= '0;
      drop_err_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        pend_addr_q[c] <= '0;
      end
    end else begin
      pend_q     <= pend_d;
      finish_q   <= finish_d;
      rr_q       <= rr_d;
      drop_err_q <= drop_err_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      for (int c = 0; c < NUM_CH; c++) begin
        pend_addr_q[c] <= pend_addr_d[c];
      end
    end
  end

  // FIFO storage; contents need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= win_addr_s;
    end
  end

  // Issue FSM: pop the head while the allocator is idle and not analysing,
  // then follow idle 1->0->1 before allowing the next issue.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q        <= READY;
      free_request_q <= 1'b0;
      free_address_q <= '0;
    end else begin
      case (state_q)
        READY: begin
          if (pop_s) begin
            free_request_q <= 1'b1;
            free_address_q <= mem_q[rd_ptr_q];
            state_q        <= WAIT_BUSY;
          end else begin
            free_request_q <= 1'b0;
          end
        end
        WAIT_BUSY: begin
          free_request_q <= 1'b0;
          if (!idle) begin
            state_q <= WAIT_IDLE;
          end
        end
        WAIT_IDLE: begin
          free_request_q <= 1'b0;
          if (idle) begin
            state_q <= READY;
          end
        end
        default: begin
          free_request_q <= 1'b0;
          state_q        <= READY;
        end
      endcase
    end
  end

  assign free_finish_o  = finish_q;
  assign free_request_o = free_request_q;
  assign free_address_o = free_address_q;
  assign count_o        = count_q;
  assign full_o         = (count_q == DEPTH_C);
  assign drop_err_o     = drop_err_q;

endmodule
